// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer -- multi-cycle MUL/DIV sequencer driving HI/LO.
//
// Accepts a one-cycle start request in IDLE and latches the operands.
// MUL uses the internal registered Booth multiplier below. DIV uses a
// 32-iteration restoring divider on magnitudes, with the signs fixed up
// when the result is written.
//
// Optional feature macro: MULDIV_DIV_EN
//   defined   : divider compiled in, err tied to 0.
//   undefined : no divider; a DIV request pulses err, div_by_zero tied to 0.
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   asynchronous active-high reset
//   start       in   operation request, sampled only in IDLE
//   op          in   0 = MUL, 1 = DIV (signed)
//   ra          in   [31:0] multiplicand / dividend
//   rb          in   [31:0] multiplier / divisor
//   busy        out  operation in flight
//   done        out  one-cycle pulse, HI/LO just written
//   hi          out  [31:0] HI register
//   lo          out  [31:0] LO register
//   div_by_zero out  last DIV had a zero divisor
//   err         out  one-cycle pulse, DIV rejected (divider compiled out)

// Registered signed radix-2 Booth multiplier: rz is valid one edge after ra/rb.
//   i_clk  in   clock
//   i_rst  in   asynchronous active-high reset
//   i_ra   in   [31:0] multiplicand
//   i_rb   in   [31:0] multiplier
//   o_rz   out  [63:0] registered signed product
module booth_multiplier (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_ra,
    input  logic [31:0] i_rb,
    output logic [63:0] o_rz
);

    logic [63:0] w_mcand;
    logic [32:0] w_rb_ext;
    logic [63:0] w_prod;

    always_comb begin
        w_mcand  = {{32{i_ra[31]}}, i_ra};
        w_rb_ext = {i_rb, 1'b0};
        w_prod   = '0;
        // Pair {rb[i], rb[i-1]}: 01 adds the shifted multiplicand, 10 subtracts it.
        for (int i = 0; i < 32; i++) begin
            case (w_rb_ext[i +: 2])
                2'b01:   w_prod = w_prod + (w_mcand << i);
                2'b10:   w_prod = w_prod - (w_mcand << i);
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_rz <= '0;
        end else begin
            o_rz <= w_prod;
        end
    end

endmodule

module muldiv_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] ra,
    input  logic [31:0] rb,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_by_zero,
    output logic        err
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_MUL_WAIT  = 3'd1;
    localparam logic [2:0] S_MUL_WRITE = 3'd2;
`ifdef MULDIV_DIV_EN
    localparam logic [2:0] S_DIV_RUN   = 3'd3;
    localparam logic [2:0] S_DIV_WRITE = 3'd4;
    localparam int unsigned DIV_CYCLES = 32;
`endif

    logic [2:0]  r_state;
    logic [2:0]  w_state_d;
    logic [31:0] r_ra;
    logic [31:0] r_rb;
    logic        r_busy;
    logic        r_done;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [63:0] w_rz;
    logic        w_accept;

    assign w_accept = (r_state == S_IDLE) && start;

    booth_multiplier u_booth (
        .i_clk (clk),
        .i_rst (reset),
        .i_ra  (r_ra),
        .i_rb  (r_rb),
        .o_rz  (w_rz)
    );

`ifdef MULDIV_DIV_EN
    logic [31:0] r_dvd;     // dividend shifting out, quotient shifting in
    logic [31:0] r_dvs;
    logic [32:0] r_rem;
    logic        r_qsign;
    logic        r_rsign;
    logic [4:0]  r_cnt;
    logic        r_dbz;
    logic [33:0] w_shift;
    logic [33:0] w_trial;
    logic        w_keep;
    logic [32:0] w_rem_d;
    logic [31:0] w_abs_ra;
    logic [31:0] w_abs_rb;

    // Magnitude of 0x80000000 wraps to itself, which is correct as unsigned 2^31.
    assign w_abs_ra = ra[31] ? -ra : ra;
    assign w_abs_rb = rb[31] ? -rb : rb;
    assign w_shift  = {r_rem, r_dvd[31]};
    assign w_trial  = w_shift - {2'b00, r_dvs};
    assign w_keep   = ~w_trial[33];
    assign w_rem_d  = w_keep ? w_trial[32:0] : w_shift[32:0];

    assign div_by_zero = r_dbz;
    assign err         = 1'b0;
`else
    logic r_err;

    assign div_by_zero = 1'b0;
    assign err         = r_err;
`endif

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
`ifdef MULDIV_DIV_EN
                    w_state_d = op ? S_DIV_RUN : S_MUL_WAIT;
`else
                    w_state_d = op ? S_IDLE : S_MUL_WAIT;
`endif
                end
            end
            S_MUL_WAIT:  w_state_d = S_MUL_WRITE;
            S_MUL_WRITE: w_state_d = S_IDLE;
`ifdef MULDIV_DIV_EN
            S_DIV_RUN: begin
                // Zero divisor short-circuits after one cycle.
                if ((r_rb == 32'd0) || (r_cnt == 5'(DIV_CYCLES - 1))) begin
                    w_state_d = S_DIV_WRITE;
                end
            end
            S_DIV_WRITE: w_state_d = S_IDLE;
`endif
            default:     w_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ra    <= '0;
            r_rb    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
`ifdef MULDIV_DIV_EN
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_rem   <= '0;
            r_qsign <= 1'b0;
            r_rsign <= 1'b0;
            r_cnt   <= '0;
            r_dbz   <= 1'b0;
`else
            r_err   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_d;
            r_busy  <= (w_state_d != S_IDLE);
            r_done  <= 1'b0;
`ifndef MULDIV_DIV_EN
            r_err   <= 1'b0;
`endif
            if (w_accept) begin
                r_ra <= ra;
                r_rb <= rb;
`ifdef MULDIV_DIV_EN
                r_dbz <= 1'b0;
                if (op) begin
                    r_dvd   <= w_abs_ra;
                    r_dvs   <= w_abs_rb;
                    r_rem   <= '0;
                    r_qsign <= ra[31] ^ rb[31];
                    r_rsign <= ra[31];
                    r_cnt   <= '0;
                end
`else
                r_err <= op;
`endif
            end

            case (r_state)
                S_MUL_WRITE: begin
                    r_hi   <= w_rz[63:32];
                    r_lo   <= w_rz[31:0];
                    r_done <= 1'b1;
                end
`ifdef MULDIV_DIV_EN
                S_DIV_RUN: begin
                    r_rem <= w_rem_d;
                    r_dvd <= {r_dvd[30:0], w_keep};
                    r_cnt <= r_cnt + 5'd1;
                end
                S_DIV_WRITE: begin
                    if (r_rb == 32'd0) begin
                        r_hi  <= r_ra;
                        r_lo  <= 32'hFFFF_FFFF;
                        r_dbz <= 1'b1;
                    end else begin
                        r_lo <= r_qsign ? -r_dvd : r_dvd;
                        r_hi <= r_rsign ? -r_rem[31:0] : r_rem[31:0];
                    end
                    r_cnt  <= '0;
                    r_done <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer.
// Follows MULDIV_DIV_EN: divider scenarios when defined, err scenarios otherwise.
module tb_muldiv_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;
    logic        err;

    int total = 0;
    int bad   = 0;

    muldiv_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .ra          (ra),
        .rb          (rb),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a request in the current cycle; returns just after the sampling edge N.
    task automatic issue(input logic o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        ra    = a;
        rb    = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 1'b0;
        ra    = 32'h0;
        rb    = 32'h0;
    endtask

    // Edges counted from N until done is seen, bounded.
    task automatic wait_done(input int limit, output int n);
        n = 0;
        while (!done && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        issue(1'b0, a, b);
        chk({tag, " busy@N"}, 32'(busy), 32'd1);
        chk({tag, " done@N"}, 32'(done), 32'd0);
        @(posedge clk);
        #1;
        chk({tag, " busy@N+1"}, 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        chk({tag, " done@N+2"}, 32'(done), 32'd1);
        chk({tag, " busy@N+2"}, 32'(busy), 32'd0);
        chk({tag, " hi"}, hi, exp_hi);
        chk({tag, " lo"}, lo, exp_lo);
    endtask

`ifdef MULDIV_DIV_EN
    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input int exp_lat, input logic [31:0] exp_hi,
                           input logic [31:0] exp_lo, input logic exp_dbz);
        int n;
        issue(1'b1, a, b);
        chk({tag, " busy@N"}, 32'(busy), 32'd1);
        wait_done(60, n);
        chk({tag, " latency"}, 32'(n), 32'(exp_lat));
        chk({tag, " hi"}, hi, exp_hi);
        chk({tag, " lo"}, lo, exp_lo);
        chk({tag, " dbz"}, 32'(div_by_zero), 32'(exp_dbz));
        chk({tag, " busy@done"}, 32'(busy), 32'd0);
    endtask
`endif

    task automatic chk_all_zero(input string tag);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " done"}, 32'(done), 32'd0);
        chk({tag, " hi"}, hi, 32'd0);
        chk({tag, " lo"}, lo, 32'd0);
        chk({tag, " dbz"}, 32'(div_by_zero), 32'd0);
        chk({tag, " err"}, 32'(err), 32'd0);
    endtask

    initial begin
        int n;
        int seen;
        reset = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        ra    = 32'h0;
        rb    = 32'h0;
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        run_mul("mul6x7", 32'd6, 32'd7, 32'h0, 32'd42);
        @(posedge clk);
        #1;
        chk("mul6x7 done drop", 32'(done), 32'd0);

        run_mul("mul5xm3", 32'd5, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
`ifdef MULDIV_DIV_EN
        // Start issued during the done cycle must be accepted.
        run_div("div100/7", 32'd100, 32'd7, 33, 32'd2, 32'd14, 1'b0);
        run_div("divm7/2", 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_div("div7/m2", 32'd7, 32'hFFFF_FFFE, 33, 32'd1, 32'hFFFF_FFFD, 1'b0);
        run_div("divovf", 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0, 32'h8000_0000, 1'b0);
        run_div("div0", 32'h0000_1234, 32'h0, 2, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1);
        issue(1'b0, 32'd2, 32'd3);
        chk("mul clears dbz", 32'(div_by_zero), 32'd0);
        wait_done(10, n);
        chk("mul2x3 lo", lo, 32'd6);
`else
        // DIV rejected: err pulse only, HI/LO keep the previous product.
        issue(1'b1, 32'd100, 32'd7);
        chk("rej err@N", 32'(err), 32'd1);
        chk("rej busy@N", 32'(busy), 32'd0);
        chk("rej hi", hi, 32'hFFFF_FFFF);
        chk("rej lo", lo, 32'hFFFF_FFF1);
        @(posedge clk);
        #1;
        chk("rej err@N+1", 32'(err), 32'd0);
        chk("rej done@N+1", 32'(done), 32'd0);
        chk("rej dbz", 32'(div_by_zero), 32'd0);
        run_mul("mul6x7b", 32'd6, 32'd7, 32'h0, 32'd42);
`endif

        run_mul("mulm4xm5", 32'hFFFF_FFFC, 32'hFFFF_FFFB, 32'h0, 32'd20);
        run_mul("mulmin2", 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);

        // Requests held while busy must be ignored.
        issue(1'b0, 32'd3, 32'd4);
        start = 1'b1;
        op    = 1'b0;
        ra    = 32'd100;
        rb    = 32'd100;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("ign mul done", 32'(done), 32'd1);
        chk("ign mul lo", lo, 32'd12);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("ign mul idle", 32'(busy), 32'd0);

`ifdef MULDIV_DIV_EN
        issue(1'b1, 32'd1000, 32'd3);
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            start = 1'b1;
            op    = k[0];
            ra    = 32'd9;
            rb    = 32'd9;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        n = 4;
        while (!done && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("ign div latency", 32'(n), 32'd33);
        chk("ign div lo", lo, 32'd333);
        chk("ign div hi", hi, 32'd1);

        // Abort a DIV mid-flight.
        issue(1'b1, 32'd50, 32'd5);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        chk("abort busy before", 32'(busy), 32'd1);
`else
        issue(1'b0, 32'd9, 32'd9);
        seen = 0;
        chk("abort busy before", 32'(busy), 32'd1);
`endif
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero("abort");
        @(negedge clk);
        reset = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        chk("abort no done", 32'(seen), 32'd0);
        chk("abort hi", hi, 32'd0);
        chk("abort lo", lo, 32'd0);

        run_mul("post reset mul", 32'd6, 32'd7, 32'h0, 32'd42);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
